// File: rtl/ili9341_view_scheduler.sv
// ili9341_view_scheduler
//
// Chooses the sprite code (visua) shown by the ILI9341 top. Pet-condition
// requests are rotated round-robin, and each granted image stays on screen for
// DWELL_FRAMES completed frames. The death request (LOCK_IDX) latches the
// MUERTO image until reset. Every decision is taken on a frame boundary, so a
// frame is never torn.
//
// Optional feature macro: ILI9341_VIEW_SCHED_WATCHDOG_EN
//   When defined, a missing frame boundary for TIMEOUT_CYC cycles forces a
//   decision tick and raises stall. When undefined, stall is constant 0.
//
// Ports:
//   clk_out      in   display-domain clock
//   rst          in   synchronous reset, active-low
//   req          in   [NUM_REQ] level requests, bit i asks for image i+1
//   frame_done   in   frame-complete level, high between frames
//   visua        out  [4] selected image code, 0 = IDLE image
//   switch_pulse out  one-cycle pulse in the first cycle visua shows a new value
//   locked       out  high once the LOCK_IDX image is latched
//   stall        out  watchdog flag
//   state_dbg    out  [2] FSM state (0 IDLE, 1 SHOW, 2 LOCK)
//
// Handshake: there is no valid/ready pair. frame_done is a level; its rising
// edge is the only event that can change the selection, and req is sampled in
// that cycle only.
`timescale 1ns/1ps
module ili9341_view_scheduler #(
    parameter int NUM_REQ      = 13,
    parameter int DWELL_FRAMES = 4,
    parameter int LOCK_IDX     = 12,
    parameter int TIMEOUT_CYC  = 2000000
) (
    input  logic               clk_out,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               frame_done,
    output logic [3:0]         visua,
    output logic               switch_pulse,
    output logic               locked,
    output logic               stall,
    output logic [1:0]         state_dbg
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW_W  = $clog2(DWELL_FRAMES) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [3:0]         visua_q, visua_d;
    logic               pulse_q, pulse_d;
    logic               locked_q, locked_d;
    logic               frame_done_q;

    logic               frame_tick;
    logic               tick;
    logic [NUM_REQ-1:0] req_other;
    logic               lock_req;
    logic               any_other;
    logic               cur_req;
    logic               dwell_done;
    logic [PTR_W:0]     cand;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;

    assign frame_tick = frame_done & ~frame_done_q;

    // The lock request never takes part in the rotation.
    assign req_other  = req & ~(NUM_REQ'(1) << LOCK_IDX);
    assign lock_req   = req[LOCK_IDX];
    assign any_other  = |req_other;
    assign cur_req    = req[rr_ptr_q];
    assign dwell_done = (dwell_q == DW_W'(DWELL_FRAMES - 1));

    // Round-robin search starting one past the last winner. The wrap is an
    // explicit subtract because NUM_REQ is not a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr_q;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k + 1);
            if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (!win_found && req_other[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

`ifdef ILI9341_VIEW_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_tick_q, wd_tick_d;
    logic            stall_q, stall_d;

    // Counts cycles since the last genuine boundary; on expiry the following
    // cycle is run as a synthetic tick.
    always_comb begin
        wd_cnt_d  = wd_cnt_q + WD_W'(1);
        wd_tick_d = 1'b0;
        if (state_q == S_LOCK || frame_tick) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
            wd_cnt_d  = '0;
            wd_tick_d = 1'b1;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (state_d == S_LOCK || frame_tick) begin
            stall_d = 1'b0;
        end else if (wd_tick_q) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            wd_cnt_q  <= '0;
            wd_tick_q <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            wd_tick_q <= wd_tick_d;
            stall_q   <= stall_d;
        end
    end

    assign tick  = frame_tick | wd_tick_q;
    assign stall = stall_q;
`else
    assign tick  = frame_tick;
    // Watchdog absent: TIMEOUT_CYC is positive, so stall is constant 0.
    assign stall = (TIMEOUT_CYC == 0);
`endif

    // State register
    always_ff @(posedge clk_out) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    if (lock_req)       state_d = S_LOCK;
                    else if (any_other) state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (tick) begin
                    if (lock_req)        state_d = S_LOCK;
                    else if (!any_other) state_d = S_IDLE;
                end
            end
            S_LOCK:  state_d = S_LOCK;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        visua_d  = visua_q;
        rr_ptr_d = rr_ptr_q;
        dwell_d  = dwell_q;
        locked_d = locked_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    if (lock_req) begin
                        visua_d  = 4'(LOCK_IDX + 1);
                        locked_d = 1'b1;
                    end else if (any_other) begin
                        visua_d  = 4'(win_idx) + 4'd1;
                        rr_ptr_d = win_idx;
                        dwell_d  = '0;
                    end
                end
            end
            S_SHOW: begin
                if (tick) begin
                    if (lock_req) begin
                        visua_d  = 4'(LOCK_IDX + 1);
                        locked_d = 1'b1;
                    end else if (!any_other) begin
                        visua_d = 4'd0;
                    end else if (!cur_req || dwell_done) begin
                        // A lone request re-wins itself, leaving visua unchanged.
                        visua_d  = 4'(win_idx) + 4'd1;
                        rr_ptr_d = win_idx;
                        dwell_d  = '0;
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
            end
            S_LOCK: begin
                visua_d  = 4'(LOCK_IDX + 1);
                locked_d = 1'b1;
            end
            default: visua_d = 4'd0;
        endcase
        pulse_d = (visua_d != visua_q);
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            rr_ptr_q     <= PTR_W'(NUM_REQ - 1);
            dwell_q      <= '0;
            visua_q      <= 4'd0;
            pulse_q      <= 1'b0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            dwell_q      <= dwell_d;
            visua_q      <= visua_d;
            pulse_q      <= pulse_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done;
        end
    end

    assign visua        = visua_q;
    assign switch_pulse = pulse_q;
    assign locked       = locked_q;
    assign state_dbg    = state_q;

endmodule
